// File: rtl/edge_pulse_pkg.sv
// Shared definitions for the edge_pulse_delay block.
//   MODE_*      : edge-select encodings for the common mode input
//   ep_state_t  : per-channel FSM state
package edge_pulse_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    PULSE = 2'd2
  } ep_state_t;

endpackage

// File: rtl/edge_pulse_channel.sv
// One channel of the edge-to-pulse generator.
//   clk, rst     : clock, synchronous active-high reset
//   sig_in       : asynchronous input for this channel
//   arm_done     : high once the shared arming window after reset has elapsed
//   mode         : edge select (bit0 = rising, bit1 = falling)
//   delay        : cycles from acceptance to pulse start
//   pulse_width  : pulse length in cycles, 0 behaves as 1
//   retrig       : 1 = edges while busy restart, 0 = ignored and flagged
//   clr_ovr      : clears ovr (a simultaneous set wins)
//   sig_out      : registered output pulse
//   busy         : channel in WAIT or PULSE
//   ovr          : sticky lost-event flag
module edge_pulse_channel
  import edge_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DELAY_W     = 8,
  parameter int WIDTH_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sig_in,
  input  logic               arm_done,
  input  logic [1:0]         mode,
  input  logic [DELAY_W-1:0] delay,
  input  logic [WIDTH_W-1:0] pulse_width,
  input  logic               retrig,
  input  logic               clr_ovr,
  output logic               sig_out,
  output logic               busy,
  output logic               ovr
);

  localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;
  logic                   sync_last;
  logic                   strobe;
  logic                   accept;

  ep_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH_W-1:0]     pw_q, pw_d;
  logic                   ovr_set;

  // Counter load for the PULSE phase: a zero width still yields one cycle.
  function automatic logic [CNT_W-1:0] pw_load(input logic [WIDTH_W-1:0] pw);
    logic [CNT_W-1:0] ext;
    ext = CNT_W'(pw);
    return (pw == '0) ? '0 : (ext - CNT_W'(1));
  endfunction

  // Counter load for the WAIT phase; only used when delay is non-zero.
  function automatic logic [CNT_W-1:0] dly_load(input logic [DELAY_W-1:0] d);
    logic [CNT_W-1:0] ext;
    ext = CNT_W'(d);
    return ext - CNT_W'(1);
  endfunction

  assign sync_last = sync_p0[SYNC_STAGES-1];

  // Stage p1 boundary: edge compare between last sync flop and prev flop.
  assign strobe = arm_done &
                  ((mode[0] &  sync_last & ~prev_p1) |
                   (mode[1] & ~sync_last &  prev_p1));

  // IDLE always accepts; a busy channel accepts only when retriggering.
  assign accept = strobe & ((state_q == IDLE) | retrig);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pw_d    = pw_q;
    ovr_set = 1'b0;
    if (accept) begin
      pw_d = pulse_width;
      if (delay == '0) begin
        state_d = PULSE;
        cnt_d   = pw_load(pulse_width);
      end else begin
        state_d = WAIT;
        cnt_d   = dly_load(delay);
      end
    end else begin
      ovr_set = strobe;
      case (state_q)
        WAIT: begin
          if (cnt_q == '0) begin
            state_d = PULSE;
            cnt_d   = pw_load(pw_q);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0 boundary: synchroniser shift, prev flop, FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pw_q    <= '0;
      sig_out <= 1'b0;
      busy    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_in};
      prev_p1 <= sync_last;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      sig_out <= (state_d == PULSE);
      busy    <= (state_d != IDLE);
      ovr     <= ovr_set | (ovr & ~clr_ovr);
    end
  end

endmodule

// File: rtl/edge_pulse_delay.sv
// Multi-channel edge-to-pulse generator with programmable delay and width.
//   clk, rst     : clock, synchronous active-high reset
//   sig_in       : N_CH asynchronous inputs
//   mode         : common edge select (00 off, 01 rise, 10 fall, 11 both)
//   delay        : cycles from accepted edge to pulse start
//   pulse_width  : pulse length in cycles (0 treated as 1)
//   retrig       : restart on edges while busy when 1, flag them when 0
//   clr_ovr      : clears all ovr flags
//   sig_out      : N_CH registered pulses
//   busy         : N_CH channel-active flags
//   ovr          : N_CH sticky lost-event flags
module edge_pulse_delay
  import edge_pulse_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DELAY_W     = 8,
  parameter int WIDTH_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    sig_in,
  input  logic [1:0]         mode,
  input  logic [DELAY_W-1:0] delay,
  input  logic [WIDTH_W-1:0] pulse_width,
  input  logic               retrig,
  input  logic               clr_ovr,
  output logic [N_CH-1:0]    sig_out,
  output logic [N_CH-1:0]    busy,
  output logic [N_CH-1:0]    ovr
);

  localparam int              ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(SYNC_STAGES + 1);

  logic [ARM_W-1:0] arm_cnt_q;
  logic             arm_done;

  // Holds strobes off until the synchronisers and prev flops have filled
  // with the real input level, so a level already high at release is silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_cnt_q <= ARM_LOAD;
    end else if (arm_cnt_q != '0) begin
      arm_cnt_q <= arm_cnt_q - ARM_W'(1);
    end
  end

  assign arm_done = (arm_cnt_q == '0);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_pulse_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DELAY_W     (DELAY_W),
      .WIDTH_W     (WIDTH_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .sig_in      (sig_in[i]),
      .arm_done    (arm_done),
      .mode        (mode),
      .delay       (delay),
      .pulse_width (pulse_width),
      .retrig      (retrig),
      .clr_ovr     (clr_ovr),
      .sig_out     (sig_out[i]),
      .busy        (busy[i]),
      .ovr         (ovr[i])
    );
  end

endmodule

// File: tb/tb_edge_pulse_delay.sv
module tb_edge_pulse_delay;

  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] sig_in;
  logic [1:0]      mode;
  logic [7:0]      delay;
  logic [7:0]      pulse_width;
  logic            retrig;
  logic            clr_ovr;
  logic [N_CH-1:0] sig_out;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] ovr;

  typedef struct {
    int ch;
    int start;
    int width;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  edge_pulse_delay #(
    .N_CH(N_CH), .SYNC_STAGES(2), .DELAY_W(8), .WIDTH_W(8)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .mode(mode), .delay(delay),
    .pulse_width(pulse_width), .retrig(retrig), .clr_ovr(clr_ovr),
    .sig_out(sig_out), .busy(busy), .ovr(ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input int start, input int width);
    exp_t e;
    e.ch = ch;
    e.start = start;
    e.width = width;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge where cyc == n (immediately if already there).
  task automatic at_neg(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every rising sig_out must match a queued pulse for that channel.
  logic [N_CH-1:0] prev_out = '0;
  int              run_len[N_CH];
  int              exp_w[N_CH];
  bit              tracked[N_CH];

  always @(negedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (sig_out[c] && !prev_out[c]) begin
        int  idx;
        idx = -1;
        for (int k = 0; k < exp_q.size(); k++)
          if (idx < 0 && exp_q[k].ch == c) idx = k;
        if (idx < 0) begin
          checks++;
          failures++;
          tracked[c] = 1'b0;
          $display("FAIL unexpected_pulse ch%0d: pulse at cycle %0d, none expected", c, cyc);
        end else begin
          chk($sformatf("pulse_start_ch%0d", c), cyc, exp_q[idx].start);
          exp_w[c] = exp_q[idx].width;
          tracked[c] = 1'b1;
          exp_q.delete(idx);
        end
        run_len[c] = 0;
      end
      if (sig_out[c]) run_len[c]++;
      if (!sig_out[c] && prev_out[c] && tracked[c]) begin
        chk($sformatf("pulse_width_ch%0d", c), run_len[c], exp_w[c]);
        tracked[c] = 1'b0;
      end
    end
    prev_out = sig_out;
  end

  initial begin
    int b;
    rst = 1'b1;
    sig_in = 4'b0001;
    mode = 2'b01;
    delay = 8'd0;
    pulse_width = 8'd1;
    retrig = 1'b0;
    clr_ovr = 1'b0;

    // Reset state, with sig_in[0] already high across release.
    @(negedge clk);
    at_neg(3);
    chk("reset_sig_out", int'(sig_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ovr", int'(ovr), 0);
    rst = 1'b0;
    at_neg(14);
    chk("arm_no_event_busy", int'(busy), 0);
    sig_in[0] = 1'b0;

    // Basic rising: delay 6, width 1.
    delay = 8'd6;
    pulse_width = 8'd1;
    b = 22;
    at_neg(b - 1);
    sig_in[0] = 1'b1;
    push(0, b + 8, 1);
    at_neg(b + 1); chk("t1_busy_e1", int'(busy[0]), 0);
    at_neg(b + 2); chk("t1_busy_e2", int'(busy[0]), 1);
    at_neg(b + 8); chk("t1_busy_e8", int'(busy[0]), 1);
    at_neg(b + 9); chk("t1_busy_e9", int'(busy[0]), 0);
    sig_in[0] = 1'b0;

    // Both edges, zero delay, width 3.
    at_neg(b + 16);
    mode = 2'b11;
    delay = 8'd0;
    pulse_width = 8'd3;
    b = 42;
    at_neg(b - 1);
    sig_in[1] = 1'b1;
    push(1, b + 2, 3);
    at_neg(b + 2); chk("t2_busy_e2", int'(busy[1]), 1);
    at_neg(b + 9);
    sig_in[1] = 1'b0;
    push(1, b + 12, 3);
    at_neg(b + 16); chk("t2_busy_done", int'(busy[1]), 0);
    mode = 2'b01;

    // No retrigger: lost edge flagged, set beats a simultaneous clear.
    retrig = 1'b0;
    delay = 8'd5;
    pulse_width = 8'd4;
    b = 66;
    at_neg(b - 1); sig_in[2] = 1'b1;
    push(2, b + 7, 4);
    at_neg(b);     sig_in[2] = 1'b0;
    at_neg(b + 2); sig_in[2] = 1'b1;
    at_neg(b + 4); chk("t3_ovr_before", int'(ovr), 0);
    at_neg(b + 5); chk("t3_ovr_set", int'(ovr), 4'b0100);
    sig_in[2] = 1'b0;
    at_neg(b + 7); sig_in[2] = 1'b1;
    at_neg(b + 9); clr_ovr = 1'b1;
    at_neg(b + 10);
    clr_ovr = 1'b0;
    chk("t3_ovr_set_wins", int'(ovr), 4'b0100);
    chk("t3_busy_last", int'(busy[2]), 1);
    at_neg(b + 11); chk("t3_busy_exit", int'(busy[2]), 0);
    at_neg(b + 12); clr_ovr = 1'b1;
    at_neg(b + 13);
    clr_ovr = 1'b0;
    chk("t3_ovr_cleared", int'(ovr), 0);

    // Retrigger during PULSE.
    retrig = 1'b1;
    delay = 8'd4;
    pulse_width = 8'd8;
    b = 86;
    at_neg(b - 1); sig_in[3] = 1'b1;
    push(3, b + 6, 3);
    push(3, b + 13, 8);
    at_neg(b + 2); sig_in[3] = 1'b0;
    at_neg(b + 6); sig_in[3] = 1'b1;
    at_neg(b + 8); chk("t4_out_before", int'(sig_out[3]), 1);
    at_neg(b + 9); chk("t4_out_dropped", int'(sig_out[3]), 0);
    chk("t4_busy_rearm", int'(busy[3]), 1);
    chk("t4_no_ovr", int'(ovr), 0);
    at_neg(b + 21); chk("t4_busy_done", int'(busy[3]), 0);
    sig_in[3] = 1'b0;
    sig_in[2] = 1'b0;

    // Reset during PULSE, input held high across release.
    retrig = 1'b0;
    delay = 8'd0;
    pulse_width = 8'd8;
    b = 116;
    at_neg(b - 1); sig_in[0] = 1'b1;
    push(0, b + 2, 3);
    at_neg(b + 4); rst = 1'b1;
    at_neg(b + 5);
    chk("t5_rst_sig_out", int'(sig_out), 0);
    chk("t5_rst_busy", int'(busy), 0);
    rst = 1'b0;
    at_neg(b + 14); chk("t5_arm_busy", int'(busy), 0);
    sig_in[0] = 1'b0;

    // All channels at once, width 0, mode off mid-WAIT.
    delay = 8'd3;
    pulse_width = 8'd0;
    b = 140;
    at_neg(b - 1); sig_in = 4'b1111;
    for (int c = 0; c < N_CH; c++) push(c, b + 5, 1);
    at_neg(b + 3); mode = 2'b00;
    at_neg(b + 4); chk("t6_busy_all", int'(busy), 4'b1111);
    at_neg(b + 5); chk("t6_out_all", int'(sig_out), 4'b1111);
    at_neg(b + 6); chk("t6_busy_none", int'(busy), 0);
    mode = 2'b01;

    at_neg(b + 16);
    chk("pending_pulses", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
